// File: rtl/axil_slave_bridge.sv
// AXI4-Lite slave bridging onto a single-outstanding req/ack register backend.
// Latency: 2 cycles minimum from AW+W (or AR) handshake to bvalid (or rvalid) when bk_ack arrives in the first request cycle.
// Backpressure: AW/W/AR ready only in IDLE; B/R held until bready/rready; a silent backend is cut off after BK_TIMEOUT cycles with SLVERR.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_aw*, s_w*, s_b*               AXI-Lite write address / data / response channels
//   s_ar*, s_r*                     AXI-Lite read address / data channels
//   bk_req/bk_we/bk_addr/bk_wdata/bk_wstrb   backend request, held until ack or timeout
//   bk_ack/bk_rdata/bk_err          backend completion, sampled only while bk_req=1
module axil_slave_bridge #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int BK_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [1:0]              s_bresp,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    bk_req,
  output logic                    bk_we,
  output logic [ADDR_WIDTH-1:0]   bk_addr,
  output logic [DATA_WIDTH-1:0]   bk_wdata,
  output logic [DATA_WIDTH/8-1:0] bk_wstrb,
  input  logic                    bk_ack,
  input  logic [DATA_WIDTH-1:0]   bk_rdata,
  input  logic                    bk_err
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  // Last request cycle index: bk_req stays high for exactly BK_TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST = 8'(BK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP
  } state_t;

  state_t                  r_state;
  logic                    r_aw_held;
  logic                    r_w_held;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_wstrb;
  logic                    r_prio_wr;
  logic [7:0]              r_timer;
  logic                    r_bk_req;
  logic                    r_bk_we;
  logic [ADDR_WIDTH-1:0]   r_bk_addr;
  logic [DATA_WIDTH-1:0]   r_bk_wdata;
  logic [STRB_WIDTH-1:0]   r_bk_wstrb;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;
  logic                    r_rvalid;
  logic [1:0]              r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic w_idle;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_wr_cand;
  logic w_wr_activity;
  logic w_wr_grant;
  logic w_rd_grant;
  logic w_done;
  logic w_err;

  assign w_idle        = (r_state == ST_IDLE);
  // A write is complete when both halves are held or arrive this cycle.
  assign w_wr_cand     = (r_aw_held | s_awvalid) & (r_w_held | s_wvalid);
  assign w_wr_activity = r_aw_held | r_w_held | s_awvalid | s_wvalid;

  // Readies are gated with rst_n so every output reads 0 while reset is held.
  assign s_awready = rst_n & w_idle & ~r_aw_held;
  assign s_wready  = rst_n & w_idle & ~r_w_held;
  // Any write activity (partial or complete) blocks AR unless the flag favours reads.
  assign s_arready = rst_n & w_idle & ~(w_wr_activity & r_prio_wr);

  assign w_aw_hs    = s_awvalid & s_awready;
  assign w_w_hs     = s_wvalid & s_wready;
  assign w_rd_grant = s_arvalid & s_arready;
  assign w_wr_grant = w_idle & w_wr_cand & (~s_arvalid | r_prio_wr);

  // Request ends on ack, or on the last allowed cycle; ack on that cycle wins.
  assign w_done = bk_ack | (r_timer == TMO_LAST);
  assign w_err  = bk_ack ? bk_err : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_prio_wr  <= 1'b1;
      r_timer    <= '0;
      r_bk_req   <= 1'b0;
      r_bk_we    <= 1'b0;
      r_bk_addr  <= '0;
      r_bk_wdata <= '0;
      r_bk_wstrb <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
      r_rvalid   <= 1'b0;
      r_rresp    <= 2'b00;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= s_awaddr;
          end
          if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= s_wdata;
            r_wstrb  <= s_wstrb;
          end
          if (w_wr_grant) begin
            r_state    <= ST_WR_REQ;
            r_bk_req   <= 1'b1;
            r_bk_we    <= 1'b1;
            r_bk_addr  <= r_aw_held ? r_awaddr : s_awaddr;
            r_bk_wdata <= r_w_held ? r_wdata : s_wdata;
            r_bk_wstrb <= r_w_held ? r_wstrb : s_wstrb;
            r_timer    <= '0;
            r_prio_wr  <= ~r_prio_wr;
          end else if (w_rd_grant) begin
            r_state    <= ST_RD_REQ;
            r_bk_req   <= 1'b1;
            r_bk_we    <= 1'b0;
            r_bk_addr  <= s_araddr;
            r_bk_wdata <= '0;
            r_bk_wstrb <= '0;
            r_timer    <= '0;
            r_prio_wr  <= ~r_prio_wr;
          end
        end

        ST_WR_REQ: begin
          if (w_done) begin
            r_state    <= ST_WR_RESP;
            r_bk_req   <= 1'b0;
            r_bk_we    <= 1'b0;
            r_bk_addr  <= '0;
            r_bk_wdata <= '0;
            r_bk_wstrb <= '0;
            r_bvalid   <= 1'b1;
            r_bresp    <= w_err ? 2'b10 : 2'b00;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        ST_WR_RESP: begin
          if (s_bready) begin
            r_state  <= ST_IDLE;
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
          end
        end

        ST_RD_REQ: begin
          if (w_done) begin
            r_state    <= ST_RD_RESP;
            r_bk_req   <= 1'b0;
            r_bk_addr  <= '0;
            r_rvalid   <= 1'b1;
            r_rresp    <= w_err ? 2'b10 : 2'b00;
            // A timed-out read returns all ones so software sees a poisoned value.
            r_rdata    <= bk_ack ? bk_rdata : '1;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        ST_RD_RESP: begin
          if (s_rready) begin
            r_state  <= ST_IDLE;
            r_rvalid <= 1'b0;
            r_rresp  <= 2'b00;
            r_rdata  <= '0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bk_req   = r_bk_req;
  assign bk_we    = r_bk_we;
  assign bk_addr  = r_bk_addr;
  assign bk_wdata = r_bk_wdata;
  assign bk_wstrb = r_bk_wstrb;
  assign s_bvalid = r_bvalid;
  assign s_bresp  = r_bresp;
  assign s_rvalid = r_rvalid;
  assign s_rresp  = r_rresp;
  assign s_rdata  = r_rdata;

endmodule

// File: tb/tb_axil_slave_bridge.sv
// Directed bench for axil_slave_bridge: write/read paths, ordering, backpressure,
// timeout, arbitration alternation and asynchronous reset mid-transaction.
// Inputs driven 1 time unit after the rising edge; outputs sampled in the same window.
module tb_axil_slave_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [14:0] s_awaddr = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [1:0]  s_bresp;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [14:0] s_araddr = '0;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        bk_req;
  logic        bk_we;
  logic [14:0] bk_addr;
  logic [31:0] bk_wdata;
  logic [3:0]  bk_wstrb;
  logic        bk_ack = 1'b0;
  logic [31:0] bk_rdata = '0;
  logic        bk_err = 1'b0;

  int total = 0;
  int bad = 0;

  wire [93:0] all_outs = {s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
                          s_rdata, s_rresp, bk_req, bk_we, bk_addr, bk_wdata, bk_wstrb};

  axil_slave_bridge #(
    .ADDR_WIDTH(15),
    .DATA_WIDTH(32),
    .BK_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr), .bk_wdata(bk_wdata),
    .bk_wstrb(bk_wstrb), .bk_ack(bk_ack), .bk_rdata(bk_rdata), .bk_err(bk_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (all_outs !== 94'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_outs); end
    @(negedge clk); rst_n = 1'b1;
    step();
    total++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin bad++; $display("FAIL reset_readies got=%b exp=111", {s_awready, s_wready, s_arready}); end
    total++; if ({bk_req, s_bvalid, s_rvalid} !== 3'b000) begin bad++; $display("FAIL reset_idle_outs got=%b exp=000", {bk_req, s_bvalid, s_rvalid}); end
  endtask

  task automatic test_write_same_cycle();
    s_bready = 1'b1;
    s_awvalid = 1'b1; s_awaddr = 15'h0010;
    s_wvalid = 1'b1; s_wdata = 32'hA5A5A5A5; s_wstrb = 4'hF;
    #1;
    total++; if ({s_awready, s_wready} !== 2'b11) begin bad++; $display("FAIL wr1_ready got=%b exp=11", {s_awready, s_wready}); end
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    total++; if ({bk_req, bk_we, bk_addr, bk_wdata, bk_wstrb} !== {1'b1, 1'b1, 15'h0010, 32'hA5A5A5A5, 4'hF})
      begin bad++; $display("FAIL wr1_bk got=%h exp=%h", {bk_req, bk_we, bk_addr, bk_wdata, bk_wstrb}, {1'b1, 1'b1, 15'h0010, 32'hA5A5A5A5, 4'hF}); end
    total++; if ({s_awready, s_wready, s_arready, s_bvalid} !== 4'b0000) begin bad++; $display("FAIL wr1_req_ready got=%b exp=0000", {s_awready, s_wready, s_arready, s_bvalid}); end
    bk_ack = 1'b1;
    step();
    bk_ack = 1'b0;
    total++; if ({bk_req, s_bvalid, s_bresp} !== 4'b0100) begin bad++; $display("FAIL wr1_resp got=%b exp=0100", {bk_req, s_bvalid, s_bresp}); end
    step();
    total++; if ({s_bvalid, s_awready} !== 2'b01) begin bad++; $display("FAIL wr1_back_idle got=%b exp=01", {s_bvalid, s_awready}); end
  endtask

  task automatic test_w_first();
    s_bready = 1'b1;
    s_wvalid = 1'b1; s_wdata = 32'hDEADBEEF; s_wstrb = 4'h6;
    step();
    s_wvalid = 1'b0;
    total++; if ({s_wready, s_awready, bk_req} !== 3'b010) begin bad++; $display("FAIL wfirst_held got=%b exp=010", {s_wready, s_awready, bk_req}); end
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (bk_req !== 1'b0) begin bad++; $display("FAIL wfirst_no_req cyc=%0d got=%b exp=0", i, bk_req); end
    end
    s_awvalid = 1'b1; s_awaddr = 15'h0100;
    step();
    s_awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if ({bk_req, bk_we, bk_addr, bk_wdata, bk_wstrb} !== {1'b1, 1'b1, 15'h0100, 32'hDEADBEEF, 4'h6})
        begin bad++; $display("FAIL wfirst_bk_stable cyc=%0d got=%h exp=%h", i, {bk_req, bk_we, bk_addr, bk_wdata, bk_wstrb}, {1'b1, 1'b1, 15'h0100, 32'hDEADBEEF, 4'h6}); end
      if (i == 3) bk_ack = 1'b1;
      step();
    end
    bk_ack = 1'b0;
    total++; if ({bk_req, s_bvalid, s_bresp} !== 4'b0100) begin bad++; $display("FAIL wfirst_resp got=%b exp=0100", {bk_req, s_bvalid, s_bresp}); end
    step();
    total++; if (s_bvalid !== 1'b0) begin bad++; $display("FAIL wfirst_bdone got=%b exp=0", s_bvalid); end
  endtask

  task automatic test_read_backpressure();
    s_rready = 1'b0;
    s_arvalid = 1'b1; s_araddr = 15'h0024;
    #1;
    total++; if (s_arready !== 1'b1) begin bad++; $display("FAIL rd_arready got=%b exp=1", s_arready); end
    step();
    s_arvalid = 1'b0;
    total++; if ({bk_req, bk_we, bk_addr} !== {1'b1, 1'b0, 15'h0024}) begin bad++; $display("FAIL rd_bk got=%h exp=%h", {bk_req, bk_we, bk_addr}, {1'b1, 1'b0, 15'h0024}); end
    bk_ack = 1'b1; bk_rdata = 32'h12345678;
    step();
    bk_ack = 1'b0; bk_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      total++; if ({s_rvalid, s_rdata, s_rresp, s_arready} !== {1'b1, 32'h12345678, 2'b00, 1'b0})
        begin bad++; $display("FAIL rd_hold cyc=%0d got=%h exp=%h", i, {s_rvalid, s_rdata, s_rresp, s_arready}, {1'b1, 32'h12345678, 2'b00, 1'b0}); end
      if (i < 4) step();
    end
    s_rready = 1'b1;
    step();
    total++; if ({s_rvalid, s_rdata, s_arready} !== {1'b0, 32'h0, 1'b1}) begin bad++; $display("FAIL rd_done got=%h exp=%h", {s_rvalid, s_rdata, s_arready}, {1'b0, 32'h0, 1'b1}); end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    s_rready = 1'b1;
    s_arvalid = 1'b1; s_araddr = 15'h0030;
    step();
    s_arvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bk_req) begin n++; step(); end
    end
    total++; if (n !== 4) begin bad++; $display("FAIL tmo_req_cycles got=%0d exp=4", n); end
    total++; if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, 2'b10, 32'hFFFFFFFF}) begin bad++; $display("FAIL tmo_resp got=%h exp=%h", {s_rvalid, s_rresp, s_rdata}, {1'b1, 2'b10, 32'hFFFFFFFF}); end
    step();
    total++; if ({s_rvalid, s_arready} !== 2'b01) begin bad++; $display("FAIL tmo_no_hang got=%b exp=01", {s_rvalid, s_arready}); end
  endtask

  task automatic test_arbitration();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step();
    s_bready = 1'b1; s_rready = 1'b1;
    s_awvalid = 1'b1; s_awaddr = 15'h0040;
    s_wvalid = 1'b1; s_wdata = 32'h11112222; s_wstrb = 4'hF;
    s_arvalid = 1'b1; s_araddr = 15'h0050;
    #1;
    total++; if ({s_awready, s_wready, s_arready} !== 3'b110) begin bad++; $display("FAIL arb1_ready got=%b exp=110", {s_awready, s_wready, s_arready}); end
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    total++; if ({bk_req, bk_we, bk_addr} !== {1'b1, 1'b1, 15'h0040}) begin bad++; $display("FAIL arb1_first_write got=%h exp=%h", {bk_req, bk_we, bk_addr}, {1'b1, 1'b1, 15'h0040}); end
    bk_ack = 1'b1; bk_err = 1'b1;
    step();
    bk_ack = 1'b0; bk_err = 1'b0;
    total++; if ({s_bvalid, s_bresp} !== 3'b110) begin bad++; $display("FAIL arb1_bresp_err got=%b exp=110", {s_bvalid, s_bresp}); end
    step();
    total++; if (s_arready !== 1'b1) begin bad++; $display("FAIL arb1_ar_ready got=%b exp=1", s_arready); end
    step();
    s_arvalid = 1'b0;
    total++; if ({bk_req, bk_we, bk_addr} !== {1'b1, 1'b0, 15'h0050}) begin bad++; $display("FAIL arb1_second_read got=%h exp=%h", {bk_req, bk_we, bk_addr}, {1'b1, 1'b0, 15'h0050}); end
    bk_ack = 1'b1; bk_rdata = 32'hCAFEF00D;
    step();
    bk_ack = 1'b0;
    total++; if ({s_rvalid, s_rdata, s_rresp} !== {1'b1, 32'hCAFEF00D, 2'b00}) begin bad++; $display("FAIL arb1_rdata got=%h exp=%h", {s_rvalid, s_rdata, s_rresp}, {1'b1, 32'hCAFEF00D, 2'b00}); end
    s_awvalid = 1'b1; s_awaddr = 15'h0060;
    s_wvalid = 1'b1; s_wdata = 32'h33334444;
    s_arvalid = 1'b1; s_araddr = 15'h0070;
    step();
    total++; if ({s_rvalid, s_awready, s_wready, s_arready} !== 4'b0110) begin bad++; $display("FAIL arb2_ready got=%b exp=0110", {s_rvalid, s_awready, s_wready, s_arready}); end
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    total++; if ({bk_req, bk_we, bk_addr, bk_wdata} !== {1'b1, 1'b1, 15'h0060, 32'h33334444}) begin bad++; $display("FAIL arb2_first_write got=%h exp=%h", {bk_req, bk_we, bk_addr, bk_wdata}, {1'b1, 1'b1, 15'h0060, 32'h33334444}); end
    bk_ack = 1'b1;
    step();
    bk_ack = 1'b0;
    total++; if ({s_bvalid, s_bresp} !== 3'b100) begin bad++; $display("FAIL arb2_bresp got=%b exp=100", {s_bvalid, s_bresp}); end
    step();
    step();
    s_arvalid = 1'b0;
    total++; if ({bk_req, bk_we, bk_addr} !== {1'b1, 1'b0, 15'h0070}) begin bad++; $display("FAIL arb2_second_read got=%h exp=%h", {bk_req, bk_we, bk_addr}, {1'b1, 1'b0, 15'h0070}); end
    bk_ack = 1'b1; bk_rdata = 32'h0BADF00D;
    step();
    bk_ack = 1'b0;
    total++; if ({s_rvalid, s_rdata} !== {1'b1, 32'h0BADF00D}) begin bad++; $display("FAIL arb2_rdata got=%h exp=%h", {s_rvalid, s_rdata}, {1'b1, 32'h0BADF00D}); end
    step();
  endtask

  task automatic test_reset_mid();
    s_bready = 1'b1; s_rready = 1'b1;
    s_awvalid = 1'b1; s_awaddr = 15'h0200;
    s_wvalid = 1'b1; s_wdata = 32'h77778888; s_wstrb = 4'h3;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    total++; if ({bk_req, bk_we} !== 2'b11) begin bad++; $display("FAIL rstmid_in_req got=%b exp=11", {bk_req, bk_we}); end
    #2; rst_n = 1'b0;
    #1;
    total++; if (all_outs !== 94'd0) begin bad++; $display("FAIL rstmid_all_zero got=%h exp=0", all_outs); end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    step();
    total++; if ({s_bvalid, bk_req, s_awready, s_wready, s_arready} !== 5'b00111) begin bad++; $display("FAIL rstmid_dropped got=%b exp=00111", {s_bvalid, bk_req, s_awready, s_wready, s_arready}); end
    s_arvalid = 1'b1; s_araddr = 15'h0008;
    step();
    s_arvalid = 1'b0;
    total++; if ({bk_req, bk_we, bk_addr} !== {1'b1, 1'b0, 15'h0008}) begin bad++; $display("FAIL rstmid_rd_bk got=%h exp=%h", {bk_req, bk_we, bk_addr}, {1'b1, 1'b0, 15'h0008}); end
    bk_ack = 1'b1; bk_rdata = 32'h55AA55AA;
    step();
    bk_ack = 1'b0;
    total++; if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, 2'b00, 32'h55AA55AA}) begin bad++; $display("FAIL rstmid_rd_resp got=%h exp=%h", {s_rvalid, s_rresp, s_rdata}, {1'b1, 2'b00, 32'h55AA55AA}); end
    step();
    total++; if (s_rvalid !== 1'b0) begin bad++; $display("FAIL rstmid_rd_done got=%b exp=0", s_rvalid); end
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_w_first();
    test_read_backpressure();
    test_timeout();
    test_arbitration();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
